// File: rtl/lane_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the lane memory arbiter.
// The arbiter takes the slave modport; requesters plus the memory sit on the master side.
interface lane_mem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 25
);
  logic              core_req;
  logic              core_lock;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;

  logic              host_req;
  logic              host_lock;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;

  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              addr_err;

  modport slave (
    input  core_req, core_lock, core_we, core_addr, core_wdata,
    input  host_req, host_lock, host_we, host_addr, host_wdata,
    input  mem_rdata,
    output core_gnt, core_rvalid, host_gnt, host_rvalid,
    output rdata, mem_en, mem_we, mem_addr, mem_wdata, addr_err
  );

  modport master (
    output core_req, core_lock, core_we, core_addr, core_wdata,
    output host_req, host_lock, host_we, host_addr, host_wdata,
    output mem_rdata,
    input  core_gnt, core_rvalid, host_gnt, host_rvalid,
    input  rdata, mem_en, mem_we, mem_addr, mem_wdata, addr_err
  );
endinterface

// File: rtl/lane_mem_arbiter.sv
// Single-port lane memory arbiter between the permutation core and the host port.
// Define LANE_ARB_ROUNDROBIN_EN to break IDLE ties in favour of the side not granted last.
module lane_mem_arbiter #(
  parameter int DEPTH    = 25,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 25,
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst,
  lane_mem_arbiter_if.slave   bus
);

  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

  typedef enum logic [1:0] {IDLE, CORE, HOST} state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                coreRvalid_q, hostRvalid_q;
  logic                addrErr_q;

  logic                ownerReq, ownerLock, ownerWe, otherReq;
  logic [ADDR_W-1:0]   ownerAddr;
  logic [DATA_W-1:0]   ownerWdata;
  logic                inRange, access, forceRelease;

  // Whoever currently owns the port drives the memory; "other" is the side that may be waiting.
  always_comb begin
    ownerReq   = 1'b0;
    ownerLock  = 1'b0;
    ownerWe    = 1'b0;
    ownerAddr  = '0;
    ownerWdata = '0;
    otherReq   = 1'b0;
    case (state_q)
      CORE: begin
        ownerReq   = bus.core_req;
        ownerLock  = bus.core_lock;
        ownerWe    = bus.core_we;
        ownerAddr  = bus.core_addr;
        ownerWdata = bus.core_wdata;
        otherReq   = bus.host_req;
      end
      HOST: begin
        ownerReq   = bus.host_req;
        ownerLock  = bus.host_lock;
        ownerWe    = bus.host_we;
        ownerAddr  = bus.host_addr;
        ownerWdata = bus.host_wdata;
        otherReq   = bus.core_req;
      end
      default: ;
    endcase
  end

  assign inRange      = {1'b0, ownerAddr} < (ADDR_W+1)'(DEPTH);
  assign access       = ownerReq && inRange;
  assign forceRelease = otherReq && (hold_q == HOLD_W'(MAX_HOLD - 1));

`ifdef LANE_ARB_ROUNDROBIN_EN
  logic lastHost_q, lastHost_d;

  always_comb begin
    lastHost_d = lastHost_q;
    if (state_d == CORE)      lastHost_d = 1'b0;
    else if (state_d == HOST) lastHost_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lastHost_q <= 1'b1;
    else      lastHost_q <= lastHost_d;
  end
`endif

  // A forced release hands over regardless of lock, so the waiting side never starves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
`ifdef LANE_ARB_ROUNDROBIN_EN
        if (bus.core_req && bus.host_req) state_d = lastHost_q ? CORE : HOST;
        else if (bus.core_req)            state_d = CORE;
        else if (bus.host_req)            state_d = HOST;
`else
        if (bus.core_req)      state_d = CORE;
        else if (bus.host_req) state_d = HOST;
`endif
      end
      CORE: begin
        if (!bus.core_req)                     state_d = bus.host_req ? HOST : IDLE;
        else if (!bus.core_lock || forceRelease) state_d = bus.host_req ? HOST : CORE;
      end
      HOST: begin
        if (!bus.host_req)                     state_d = bus.core_req ? CORE : IDLE;
        else if (!bus.host_lock || forceRelease) state_d = bus.core_req ? CORE : HOST;
      end
      default: state_d = IDLE;
    endcase
    hold_d = (state_d == state_q && state_q != IDLE && otherReq) ? hold_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      coreRvalid_q <= 1'b0;
      hostRvalid_q <= 1'b0;
      addrErr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      coreRvalid_q <= (state_q == CORE) && access && !ownerWe;
      hostRvalid_q <= (state_q == HOST) && access && !ownerWe;
      if (ownerReq && !inRange) addrErr_q <= 1'b1;
    end
  end

  assign bus.core_gnt    = (state_q == CORE);
  assign bus.host_gnt    = (state_q == HOST);
  assign bus.core_rvalid = coreRvalid_q;
  assign bus.host_rvalid = hostRvalid_q;
  assign bus.rdata       = (coreRvalid_q || hostRvalid_q) ? bus.mem_rdata : '0;
  assign bus.mem_en      = access;
  assign bus.mem_we      = access && ownerWe;
  assign bus.mem_addr    = ownerAddr;
  assign bus.mem_wdata   = ownerWdata;
  assign bus.addr_err    = addrErr_q;

endmodule

// File: doc/lane_mem_arbiter.md
# lane_mem_arbiter

Arbitrates single-port access to the 25-entry lane memory between the permutation core datapath and the host load/unload port. Owns the memory's enable, write-enable, address and write-data lines. Returns read data to whichever requester issued the read. Lets a requester lock the port for multi-cycle bursts, and forces release after a bounded hold so the other side cannot starve.

## Interface
Parameters:
- DEPTH, 25, number of memory words; valid addresses are 0..DEPTH-1
- ADDR_W, 5, address width
- DATA_W, 25, data word width
- MAX_HOLD, 8, maximum consecutive granted cycles while the other side is requesting

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- core_req  in  1  core requests the port
- core_lock  in  1  core asks to keep the grant after the current access
- core_we  in  1  core write (1) / read (0)
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  core owns the port this cycle
- core_rvalid  out  1  core read data is valid
- host_req, host_lock, host_we, host_addr, host_wdata, host_gnt, host_rvalid  same as the core_ signals, for the host side
- rdata  out  DATA_W  read data, shared by both sides and qualified by the *_rvalid signals
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  synchronous memory output, valid the cycle after a read
- addr_err  out  1  sticky flag: an out-of-range access was attempted

## Operation
- FSM states: IDLE, CORE, HOST. State is registered and resets to IDLE.
- IDLE → CORE if core_req; otherwise IDLE → HOST if host_req. With both requesting, the tie-break is set by the Configuration section.
- CORE stays in CORE while core_req=1 and core_lock=1 and no forced release is pending.
- CORE, when core_req=0: go to HOST if host_req, else IDLE.
- CORE, when core_req=1 and core_lock=0: go to HOST if host_req, else stay CORE.
- HOST transitions mirror CORE.
- Grants: core_gnt = (state==CORE); host_gnt = (state==HOST). The grants are never both high.
- Memory access: when the owner's req=1, drive mem_en=1 and pass the owner's we/addr/wdata through to the mem_* lines. Otherwise mem_en=0 and mem_we=0.
- Out-of-range access (owner addr >= DEPTH): force mem_en=0 and mem_we=0, and set addr_err. addr_err clears only on reset.
- Hold counter (width clog2(MAX_HOLD)+1):
  - Increments each cycle the state is unchanged and the other side has req=1.
  - Clears on any state change and whenever the other side's req=0.
  - When the count reaches MAX_HOLD-1, the next edge forces a switch to the other side, regardless of lock.
- Read return: a granted in-range read sets that owner's rvalid for exactly the following cycle, with rdata=mem_rdata. rvalid is routed to the issuing side even if the grant has since switched.
- Reset asserted mid-burst: state → IDLE, all outputs go to their reset values immediately, and any in-flight rvalid is dropped.

## Timing
- Reset values: core_gnt=0, host_gnt=0, core_rvalid=0, host_rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, addr_err=0.
- Grant latency: a req seen in IDLE gives gnt on the next cycle. No access is issued in the request cycle.
- The first access is issued in the first gnt cycle; after that, one access per cycle while req stays high.
- Read latency: rvalid and rdata follow the issuing cycle by 1 cycle.
- Switch latency: the new owner's gnt rises in the same cycle the old owner's gnt falls. There are no dead cycles between owners.
- Write followed by a read to the same address on the next cycle returns the new data; memory write-first behaviour is relied on.

## Configuration
- LANE_ARB_ROUNDROBIN_EN defined:
  - On a simultaneous request from IDLE, the side that was not granted most recently wins.
  - A "last owner" register resets to HOST, so the core wins the first tie.
- LANE_ARB_ROUNDROBIN_EN undefined:
  - The core always wins ties from IDLE.
  - The "last owner" register is not built.
  - Hold-counter forced release still applies.

## Test plan
- Reset: hold rst=0 with both req=1 → all outputs 0 and state IDLE. Release → core_gnt=1 one cycle later.
- Core read burst: core_req=1, core_lock=1, addresses 0..4, host idle → five consecutive mem_en pulses. core_rvalid is high for five cycles, each lagging its read by 1.
- Starvation guard: core locks continuously while host_req=1 → host_gnt rises after exactly MAX_HOLD=8 core-granted cycles.
- Unlocked alternation: both req=1, both lock=0 → grants alternate CORE/HOST every cycle. mem_en stays high throughout.
- Address error: host write to addr 25 → mem_en=0 that cycle, and addr_err=1 latched until reset.
- Tie-break: both sides request from IDLE twice, returning to IDLE in between. With LANE_ARB_ROUNDROBIN_EN the first winner is CORE and the second is HOST; without it, CORE wins both.
